// File: rtl/cap_ctrl.sv
// Camera frame capture controller: arms on START, gates HREF between
// VSYNC edges, counts lines and frames, and flags overflow/line errors.
module cap_ctrl #(
   parameter logic [10:0] EXP_LINES = 11'd1024
) (
   input  logic        PCLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        CONT,
   input  logic        STOP,
   input  logic        ERR_CLR,
   input  logic        VSYNC,
   input  logic        HREF,
   input  logic        FIFO_FULL,
   output logic        HREF_O,
   output logic        BUSY,
   output logic        DONE,
   output logic        OVF,
   output logic        LINE_ERR,
   output logic [15:0] FRAME_CNT,
   output logic [10:0] LINE_CNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SYNC,
      S_CAP,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic        cap_en_q, cap_en_d;
   logic        cont_q, cont_d;
   logic        stop_q, stop_d;
   logic        vs_q, hr_q;
   logic [10:0] lines_q, lines_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic        lerr_q, lerr_d;
   logic        busy_q;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [10:0] line_cnt_q, line_cnt_d;

   logic vs_rise, vs_fall, hr_fall, href_g;

   assign vs_rise = VSYNC & ~vs_q;
   assign vs_fall = ~VSYNC & vs_q;
   assign hr_fall = ~HREF & hr_q;
   assign href_g  = HREF & cap_en_q;

   always_comb begin
      state_d     = state_q;
      cap_en_d    = cap_en_q;
      cont_d      = cont_q;
      stop_d      = stop_q;
      lines_d     = lines_q;
      done_d      = 1'b0;
      ovf_d       = ovf_q;
      lerr_d      = lerr_q;
      frame_cnt_d = frame_cnt_q;
      line_cnt_d  = line_cnt_q;
      if (ERR_CLR) begin
         ovf_d  = 1'b0;
         lerr_d = 1'b0;
      end
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_ARM;
               cont_d  = CONT;
               stop_d  = 1'b0;
            end
         end
         S_ARM: begin
            if (STOP) begin
               state_d = S_IDLE;
            end else if (VSYNC) begin
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (STOP) begin
               state_d = S_IDLE;
            end else if (vs_fall) begin
               state_d  = S_CAP;
               cap_en_d = 1'b1;
               lines_d  = '0;
            end
         end
         S_CAP: begin
            if (STOP) begin
               stop_d = 1'b1;
            end
            if (hr_fall && (lines_q != 11'h7FF)) begin
               lines_d = lines_q + 11'd1;
            end
            // Overflow aborts the frame even if VSYNC rises in the same cycle
            if (FIFO_FULL && href_g) begin
               ovf_d    = 1'b1;
               cap_en_d = 1'b0;
               state_d  = S_IDLE;
            end else if (vs_rise) begin
               cap_en_d    = 1'b0;
               state_d     = S_FIN;
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
               line_cnt_d  = lines_d;
               if (lines_d != EXP_LINES) begin
                  lerr_d = 1'b1;
               end
            end
         end
         S_FIN: begin
            if (cont_q && !stop_q && !STOP) begin
               state_d = S_SYNC;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         cap_en_q    <= 1'b0;
         cont_q      <= 1'b0;
         stop_q      <= 1'b0;
         vs_q        <= 1'b0;
         hr_q        <= 1'b0;
         lines_q     <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         lerr_q      <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
         line_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cap_en_q    <= cap_en_d;
         cont_q      <= cont_d;
         stop_q      <= stop_d;
         vs_q        <= VSYNC;
         hr_q        <= HREF;
         lines_q     <= lines_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         lerr_q      <= lerr_d;
         busy_q      <= (state_d != S_IDLE);
         frame_cnt_q <= frame_cnt_d;
         line_cnt_q  <= line_cnt_d;
      end
   end

   assign HREF_O    = href_g;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign OVF       = ovf_q;
   assign LINE_ERR  = lerr_q;
   assign FRAME_CNT = frame_cnt_q;
   assign LINE_CNT  = line_cnt_q;

endmodule

// File: tb/tb_cap_ctrl.sv
// Self-checking bench for cap_ctrl: control vector table, directed
// frame scenarios and randomized frames against a frame-level model.
module tb_cap_ctrl;

   logic        PCLK;
   logic        RST_N;
   logic        START, CONT, STOP, ERR_CLR;
   logic        VSYNC, HREF, FIFO_FULL;
   logic        HREF_O, BUSY, DONE, OVF, LINE_ERR;
   logic [15:0] FRAME_CNT;
   logic [10:0] LINE_CNT;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int hro_cnt = 0;
   logic done_prev = 1'b0;

   cap_ctrl #(.EXP_LINES(11'd1024)) dut (
      .PCLK(PCLK),
      .RST_N(RST_N),
      .START(START),
      .CONT(CONT),
      .STOP(STOP),
      .ERR_CLR(ERR_CLR),
      .VSYNC(VSYNC),
      .HREF(HREF),
      .FIFO_FULL(FIFO_FULL),
      .HREF_O(HREF_O),
      .BUSY(BUSY),
      .DONE(DONE),
      .OVF(OVF),
      .LINE_ERR(LINE_ERR),
      .FRAME_CNT(FRAME_CNT),
      .LINE_CNT(LINE_CNT)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Event monitor: DONE pulses, HREF_O cycles, DONE never two cycles long
   always @(negedge PCLK) begin
      if (RST_N) begin
         if (DONE) begin
            done_cnt++;
            checks++;
            if (done_prev) begin
               errors++;
               $display("FAIL done_width: DONE high two cycles, required one");
            end
         end
         if (HREF_O) hro_cnt++;
         done_prev = DONE;
      end else begin
         done_prev = 1'b0;
      end
   end

   typedef struct {
      logic        st, ct, sp, vs, hr, ff, ec;
      logic        busy, hro, done, ovf, lerr;
      logic [15:0] fcnt;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      START = 0; CONT = 0; STOP = 0; ERR_CLR = 0;
      VSYNC = 0; HREF = 0; FIFO_FULL = 0;
      repeat (2) tick();
      @(negedge PCLK);
      RST_N = 1'b1;
      tick();
   endtask

   task automatic start_cap(input logic c);
      START = 1'b1;
      CONT  = c;
      tick();
      START = 1'b0;
      CONT  = 1'b0;
   endtask

   task automatic stop_pulse();
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
   endtask

   task automatic clr_pulse();
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
   endtask

   task automatic vs_pulse();
      VSYNC = 1'b1;
      repeat (4) tick();
      VSYNC = 1'b0;
      repeat (3) tick();
   endtask

   task automatic lines(input int n, input int hi, input int lo,
                        input int ffl);
      for (int l = 0; l < n; l++) begin
         for (int c = 0; c < hi; c++) begin
            HREF = 1'b1;
            FIFO_FULL = (l == ffl) && (c == 0);
            tick();
         end
         FIFO_FULL = 1'b0;
         HREF = 1'b0;
         repeat (lo) tick();
      end
      repeat (3) tick();
   endtask

   initial begin
      int d0, h0;
      int m_frames, m_lcnt;
      logic m_lerr, m_ovf;

      // st ct sp vs hr ff ec | busy hro done ovf lerr fcnt
      vt[0]  = '{0,0,1,0,0,0,0, 0,0,0,0,0, 16'd0};
      vt[1]  = '{1,0,1,0,0,0,0, 1,0,0,0,0, 16'd0};
      vt[2]  = '{0,0,1,0,0,0,0, 0,0,0,0,0, 16'd0};
      vt[3]  = '{1,0,0,0,0,0,0, 1,0,0,0,0, 16'd0};
      vt[4]  = '{0,0,0,1,0,0,0, 1,0,0,0,0, 16'd0};
      vt[5]  = '{0,0,1,1,0,0,0, 0,0,0,0,0, 16'd0};
      vt[6]  = '{1,0,0,1,0,0,0, 1,0,0,0,0, 16'd0};
      vt[7]  = '{0,0,0,1,0,0,0, 1,0,0,0,0, 16'd0};
      vt[8]  = '{0,0,0,0,1,0,0, 1,1,0,0,0, 16'd0};
      vt[9]  = '{0,0,0,0,0,0,0, 1,0,0,0,0, 16'd0};
      vt[10] = '{1,0,0,0,1,0,0, 1,1,0,0,0, 16'd0};
      vt[11] = '{0,0,0,1,1,0,0, 1,0,1,0,1, 16'd1};
      vt[12] = '{0,0,0,1,0,0,0, 0,0,0,0,1, 16'd1};
      vt[13] = '{0,0,0,0,0,0,1, 0,0,0,0,0, 16'd1};
      vt[14] = '{0,0,0,0,1,0,0, 0,0,0,0,0, 16'd1};

      RST_N = 1'b0;
      START = 0; CONT = 0; STOP = 0; ERR_CLR = 0;
      VSYNC = 0; HREF = 1; FIFO_FULL = 0;
      #12;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ovf", OVF, 0);
      chk("rst_lerr", LINE_ERR, 0);
      chk("rst_fcnt", FRAME_CNT, 0);
      chk("rst_lcnt", LINE_CNT, 0);
      chk("rst_hro", HREF_O, 0);

      // Control-path vector table
      do_reset();
      for (int i = 0; i < 15; i++) begin
         START = vt[i].st; CONT = vt[i].ct; STOP = vt[i].sp;
         VSYNC = vt[i].vs; HREF = vt[i].hr; FIFO_FULL = vt[i].ff;
         ERR_CLR = vt[i].ec;
         tick();
         chk($sformatf("vec%0d_busy", i), BUSY, vt[i].busy);
         chk($sformatf("vec%0d_hro", i), HREF_O, vt[i].hro);
         chk($sformatf("vec%0d_done", i), DONE, vt[i].done);
         chk($sformatf("vec%0d_ovf", i), OVF, vt[i].ovf);
         chk($sformatf("vec%0d_lerr", i), LINE_ERR, vt[i].lerr);
         chk($sformatf("vec%0d_fcnt", i), FRAME_CNT, vt[i].fcnt);
      end
      chk("vec_lcnt", LINE_CNT, 1);

      // Start mid-frame, single 1024-line frame
      do_reset();
      start_cap(1'b0);
      h0 = hro_cnt; d0 = done_cnt;
      lines(20, 1, 1, -1);
      chk("mid_hro", hro_cnt - h0, 0);
      chk("mid_busy", BUSY, 1);
      vs_pulse();
      lines(1024, 1, 1, -1);
      vs_pulse();
      chk("f1_done", done_cnt - d0, 1);
      chk("f1_fcnt", FRAME_CNT, 1);
      chk("f1_lcnt", LINE_CNT, 1024);
      chk("f1_lerr", LINE_ERR, 0);
      chk("f1_busy", BUSY, 0);
      chk("f1_hro", hro_cnt - h0, 1024);

      // Continuous mode, STOP during frame 3
      do_reset();
      start_cap(1'b1);
      d0 = done_cnt;
      vs_pulse();
      lines(1024, 1, 1, -1);
      vs_pulse();
      lines(1024, 1, 1, -1);
      vs_pulse();
      lines(500, 1, 1, -1);
      stop_pulse();
      lines(524, 1, 1, -1);
      vs_pulse();
      chk("cont_done", done_cnt - d0, 3);
      chk("cont_fcnt", FRAME_CNT, 3);
      chk("cont_busy", BUSY, 0);
      h0 = hro_cnt;
      lines(30, 1, 1, -1);
      vs_pulse();
      lines(30, 1, 1, -1);
      chk("cont_after_hro", hro_cnt - h0, 0);
      chk("cont_after_fcnt", FRAME_CNT, 3);

      // Overflow on line 10, ERR_CLR coincident with the set
      do_reset();
      start_cap(1'b0);
      d0 = done_cnt;
      vs_pulse();
      h0 = hro_cnt;
      lines(10, 2, 1, -1);
      HREF = 1'b1; FIFO_FULL = 1'b1; ERR_CLR = 1'b1;
      tick();
      FIFO_FULL = 1'b0; ERR_CLR = 1'b0;
      chk("ovf_set", OVF, 1);
      chk("ovf_hro", HREF_O, 0);
      chk("ovf_busy", BUSY, 0);
      tick();
      HREF = 1'b0;
      lines(20, 2, 1, -1);
      vs_pulse();
      chk("ovf_done", done_cnt - d0, 0);
      chk("ovf_fcnt", FRAME_CNT, 0);
      chk("ovf_hro_cnt", hro_cnt - h0, 21);
      chk("ovf_sticky", OVF, 1);
      clr_pulse();
      chk("ovf_clr", OVF, 0);

      // 1000-line frame
      do_reset();
      start_cap(1'b0);
      d0 = done_cnt;
      vs_pulse();
      lines(1000, 1, 1, -1);
      vs_pulse();
      chk("short_done", done_cnt - d0, 1);
      chk("short_lcnt", LINE_CNT, 1000);
      chk("short_lerr", LINE_ERR, 1);

      // Async reset during line 500
      start_cap(1'b0);
      vs_pulse();
      lines(500, 1, 1, -1);
      HREF = 1'b1;
      tick();
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_busy", BUSY, 0);
      chk("arst_done", DONE, 0);
      chk("arst_ovf", OVF, 0);
      chk("arst_lerr", LINE_ERR, 0);
      chk("arst_fcnt", FRAME_CNT, 0);
      chk("arst_lcnt", LINE_CNT, 0);
      chk("arst_hro", HREF_O, 0);
      @(negedge PCLK);
      RST_N = 1'b1;
      tick();
      chk("arst_rel_busy", BUSY, 0);
      d0 = done_cnt; h0 = hro_cnt;
      HREF = 1'b0;
      lines(100, 1, 1, -1);
      vs_pulse();
      lines(50, 1, 1, -1);
      vs_pulse();
      chk("arst_idle_done", done_cnt - d0, 0);
      chk("arst_idle_hro", hro_cnt - h0, 0);
      start_cap(1'b0);
      vs_pulse();
      lines(1024, 1, 1, -1);
      vs_pulse();
      chk("arst_new_done", done_cnt - d0, 1);
      chk("arst_new_fcnt", FRAME_CNT, 1);
      chk("arst_new_lcnt", LINE_CNT, 1024);
      chk("arst_new_lerr", LINE_ERR, 0);

      // Line counter saturation
      do_reset();
      start_cap(1'b0);
      vs_pulse();
      lines(2050, 1, 1, -1);
      vs_pulse();
      chk("sat_lcnt", LINE_CNT, 11'h7FF);
      chk("sat_lerr", LINE_ERR, 1);

      // Frame counter wrap from a forced FFFF
      do_reset();
      @(negedge PCLK);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge PCLK);
      release dut.frame_cnt_q;
      d0 = done_cnt;
      start_cap(1'b0);
      vs_pulse();
      lines(1024, 1, 1, -1);
      vs_pulse();
      chk("wrap_fcnt", FRAME_CNT, 0);
      chk("wrap_done", done_cnt - d0, 1);
      chk("wrap_lcnt", LINE_CNT, 1024);
      chk("wrap_lerr", LINE_ERR, 0);
      chk("wrap_ovf", OVF, 0);

      // Randomized frames against a frame-level model
      do_reset();
      m_frames = 0; m_lcnt = 0; m_lerr = 0; m_ovf = 0;
      for (int it = 0; it < 6; it++) begin
         int n, hi, lo, ffl, exp_h, exp_d;
         bit clr;
         n   = ($urandom_range(0, 2) == 0) ? 1024 : $urandom_range(1, 200);
         hi  = $urandom_range(1, 2);
         lo  = $urandom_range(1, 2);
         ffl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         clr = ($urandom_range(0, 3) == 0);
         d0 = done_cnt; h0 = hro_cnt;
         start_cap(1'b0);
         vs_pulse();
         lines(n, hi, lo, ffl);
         vs_pulse();
         if (ffl >= 0) begin
            m_ovf = 1'b1;
            exp_h = ffl * hi + 1;
            exp_d = 0;
         end else begin
            m_frames = (m_frames + 1) % 65536;
            m_lcnt   = n;
            if (n != 1024) m_lerr = 1'b1;
            exp_h = n * hi;
            exp_d = 1;
         end
         if (clr) begin
            clr_pulse();
            m_ovf  = 1'b0;
            m_lerr = 1'b0;
         end
         chk($sformatf("rnd%0d_done", it), done_cnt - d0, exp_d);
         chk($sformatf("rnd%0d_hro", it), hro_cnt - h0, exp_h);
         chk($sformatf("rnd%0d_fcnt", it), FRAME_CNT, m_frames);
         chk($sformatf("rnd%0d_lcnt", it), LINE_CNT, m_lcnt);
         chk($sformatf("rnd%0d_lerr", it), LINE_ERR, m_lerr);
         chk($sformatf("rnd%0d_ovf", it), OVF, m_ovf);
         chk($sformatf("rnd%0d_busy", it), BUSY, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
